// File: rtl/window_vote_filter_pkg.sv
// Shared types and width helpers for the window vote filter.
// Widths are derived from window geometry so every instance agrees on them.
package window_vote_pkg;

  typedef enum logic [1:0] {
    VOTE_THRESH = 2'd0,
    VOTE_ERODE  = 2'd1,
    VOTE_DILATE = 2'd2,
    VOTE_BYPASS = 2'd3
  } vote_mode_e;

  // Bits needed to hold a column count 0..win_h.
  function automatic int cs_width(input int win_h);
    return $clog2(win_h + 1);
  endfunction

  // Bits needed to hold the full window count win_w*win_h.
  function automatic int sum_width(input int win_w, input int win_h);
    return $clog2(win_w * win_h + 1);
  endfunction

  // Simple-majority threshold used until the first frame start programs one.
  function automatic int default_thresh(input int win_w, input int win_h);
    return (win_w * win_h) / 2;
  endfunction

endpackage

// File: rtl/window_vote_filter_col_popcount.sv
// Counts the set bits of one column slice; purely combinational.
// Latency 0; no flow control.
module col_popcount
  import window_vote_pkg::*;
#(
  parameter int WIN_H = 5,
  parameter int CS_W  = cs_width(WIN_H)
) (
  input  logic [WIN_H-1:0] i_col,
  output logic [CS_W-1:0]  o_cnt
);

  always_comb begin
    o_cnt = '0;
    for (int i = 0; i < WIN_H; i++) begin
      o_cnt = o_cnt + CS_W'(i_col[i]);
    end
  end

endmodule

// File: rtl/window_vote_filter.sv
// Streaming 2-D vote filter: column counts, sliding WIN_W-column sum, vote, grid tags.
// Latency 2 cycles i_valid -> o_valid; never stalls, input gaps simply hold all state.
module window_vote_filter
  import window_vote_pkg::*;
#(
  parameter int WIN_W = 8,
  parameter int WIN_H = 5,
  parameter int COLS  = 160,
  parameter int ROWS  = 72,
  parameter int CS_W  = cs_width(WIN_H),
  parameter int SUM_W = sum_width(WIN_W, WIN_H),
  parameter int X_W   = $clog2(COLS),
  parameter int Y_W   = $clog2(ROWS)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_valid,
  input  logic             i_sof,
  input  logic             i_sol,
  input  logic [WIN_H-1:0] i_col,
  input  logic [SUM_W-1:0] i_thresh,
  input  logic [1:0]       i_mode,
  output logic             o_valid,
  output logic             o_bit,
  output logic [SUM_W-1:0] o_sum,
  output logic [X_W-1:0]   o_x,
  output logic [Y_W-1:0]   o_y,
  output logic             o_eol,
  output logic             o_eof,
  output logic             o_ovf
);

  localparam logic [SUM_W-1:0] FULL_SUM = SUM_W'(WIN_W * WIN_H);
  localparam logic [SUM_W-1:0] DEF_TH   = SUM_W'(default_thresh(WIN_W, WIN_H));
  localparam logic [X_W-1:0]   X_MAX    = X_W'(COLS - 1);
  localparam logic [Y_W-1:0]   Y_MAX    = Y_W'(ROWS - 1);

  logic [CS_W-1:0] col_cnt;

  col_popcount #(
    .WIN_H (WIN_H),
    .CS_W  (CS_W)
  ) u_popcount (
    .i_col (i_col),
    .o_cnt (col_cnt)
  );

  // Stage 1: column count plus beat flags, and frame configuration.
  logic             s1_vld_q, s1_vld_d;
  logic             s1_sof_q, s1_sof_d;
  logic             s1_sol_q, s1_sol_d;
  logic             s1_ctr_q, s1_ctr_d;
  logic [CS_W-1:0]  s1_cnt_q, s1_cnt_d;
  logic [SUM_W-1:0] cfg_thresh_q, cfg_thresh_d;
  vote_mode_e       cfg_mode_q, cfg_mode_d;

  always_comb begin
    s1_vld_d     = i_valid;
    s1_sof_d     = s1_sof_q;
    s1_sol_d     = s1_sol_q;
    s1_ctr_d     = s1_ctr_q;
    s1_cnt_d     = s1_cnt_q;
    cfg_thresh_d = cfg_thresh_q;
    cfg_mode_d   = cfg_mode_q;
    if (i_valid) begin
      s1_sof_d = i_sof;
      // A frame start is also a line start.
      s1_sol_d = i_sof | i_sol;
      s1_ctr_d = i_col[WIN_H/2];
      s1_cnt_d = col_cnt;
      if (i_sof) begin
        cfg_thresh_d = i_thresh;
        cfg_mode_d   = vote_mode_e'(i_mode);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_vld_q     <= 1'b0;
      s1_sof_q     <= 1'b0;
      s1_sol_q     <= 1'b0;
      s1_ctr_q     <= 1'b0;
      s1_cnt_q     <= '0;
      cfg_thresh_q <= DEF_TH;
      cfg_mode_q   <= VOTE_THRESH;
    end else begin
      s1_vld_q     <= s1_vld_d;
      s1_sof_q     <= s1_sof_d;
      s1_sol_q     <= s1_sol_d;
      s1_ctr_q     <= s1_ctr_d;
      s1_cnt_q     <= s1_cnt_d;
      cfg_thresh_q <= cfg_thresh_d;
      cfg_mode_q   <= cfg_mode_d;
    end
  end

  // Stage 2: column history, running sum, coordinates and registered outputs.
  logic [WIN_W-1:0][CS_W-1:0] hist_q, hist_d;
  logic [SUM_W-1:0]           sum_q, sum_d;
  logic [X_W-1:0]             x_q, x_d;
  logic [Y_W-1:0]             y_q, y_d;
  logic                       seen_q, seen_d;
  logic                       ovf_q, ovf_d;
  logic                       valid_q, valid_d;
  logic                       bit_q, bit_d;
  logic                       eol_q, eol_d;
  logic                       eof_q, eof_d;

  always_comb begin
    hist_d  = hist_q;
    sum_d   = sum_q;
    x_d     = x_q;
    y_d     = y_q;
    seen_d  = seen_q;
    ovf_d   = ovf_q;
    valid_d = s1_vld_q;
    bit_d   = bit_q;
    eol_d   = eol_q;
    eof_d   = eof_q;
    if (s1_vld_q) begin
      seen_d = 1'b1;
      if (s1_sol_q) begin
        // Left-edge zero padding: the window restarts with only this column.
        hist_d    = '0;
        hist_d[0] = s1_cnt_q;
        sum_d     = SUM_W'(s1_cnt_q);
      end else begin
        for (int k = WIN_W - 1; k > 0; k--) begin
          hist_d[k] = hist_q[k-1];
        end
        hist_d[0] = s1_cnt_q;
        sum_d     = sum_q + SUM_W'(s1_cnt_q) - SUM_W'(hist_q[WIN_W-1]);
      end

      // Beats seen before any frame start count from the origin.
      if (s1_sof_q || !seen_q) begin
        x_d = '0;
        y_d = '0;
        if (s1_sof_q) begin
          ovf_d = 1'b0;
        end
      end else if (s1_sol_q) begin
        x_d = '0;
        if (y_q == Y_MAX) begin
          ovf_d = 1'b1;
        end else begin
          y_d = y_q + Y_W'(1);
        end
      end else if (x_q == X_MAX) begin
        ovf_d = 1'b1;
      end else begin
        x_d = x_q + X_W'(1);
      end

      eol_d = (x_d == X_MAX);
      eof_d = eol_d && (y_d == Y_MAX);

      case (cfg_mode_q)
        VOTE_THRESH: bit_d = (sum_d >= cfg_thresh_q);
        VOTE_ERODE:  bit_d = (sum_d == FULL_SUM);
        VOTE_DILATE: bit_d = (sum_d != '0);
        VOTE_BYPASS: bit_d = s1_ctr_q;
        default:     bit_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hist_q  <= '0;
      sum_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      seen_q  <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      bit_q   <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      sum_q   <= sum_d;
      x_q     <= x_d;
      y_q     <= y_d;
      seen_q  <= seen_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      bit_q   <= bit_d;
      eol_q   <= eol_d;
      eof_q   <= eof_d;
    end
  end

  assign o_valid = valid_q;
  assign o_bit   = bit_q;
  assign o_sum   = sum_q;
  assign o_x     = x_q;
  assign o_y     = y_q;
  assign o_eol   = eol_q;
  assign o_eof   = eof_q;
  assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_window_vote_filter.sv
// Directed bench for window_vote_filter (8x5 window, 160x72 grid).
// Expected sums/bits are hand-derived per vector; outputs are checked against a queue.
module tb_window_vote_filter;

  localparam int COLS = 160;
  localparam int ROWS = 72;

  logic       clk;
  logic       rstn;
  logic       i_valid;
  logic       i_sof;
  logic       i_sol;
  logic [4:0] i_col;
  logic [5:0] i_thresh;
  logic [1:0] i_mode;
  logic       o_valid;
  logic       o_bit;
  logic [5:0] o_sum;
  logic [7:0] o_x;
  logic [6:0] o_y;
  logic       o_eol;
  logic       o_eof;
  logic       o_ovf;

  window_vote_filter dut (
    .clk      (clk),
    .rstn     (rstn),
    .i_valid  (i_valid),
    .i_sof    (i_sof),
    .i_sol    (i_sol),
    .i_col    (i_col),
    .i_thresh (i_thresh),
    .i_mode   (i_mode),
    .o_valid  (o_valid),
    .o_bit    (o_bit),
    .o_sum    (o_sum),
    .o_x      (o_x),
    .o_y      (o_y),
    .o_eol    (o_eol),
    .o_eof    (o_eof),
    .o_ovf    (o_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int sum;
    bit b;
    int x;
    int y;
    bit eol;
    bit eof;
    bit ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_out = 0;

  // Expected coordinate state of the next output beat.
  int m_x = 0;
  int m_y = 0;
  bit m_seen = 0;
  bit m_ovf = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send(input bit sof, input bit sol, input logic [4:0] col,
                      input int esum, input bit ebit);
    exp_t e;
    if (sof || !m_seen) begin
      m_x = 0;
      m_y = 0;
      if (sof) m_ovf = 0;
    end else if (sol) begin
      m_x = 0;
      if (m_y == ROWS - 1) m_ovf = 1;
      else m_y++;
    end else if (m_x == COLS - 1) begin
      m_ovf = 1;
    end else begin
      m_x++;
    end
    m_seen = 1;
    e.sum = esum;
    e.b   = ebit;
    e.x   = m_x;
    e.y   = m_y;
    e.eol = (m_x == COLS - 1);
    e.eof = e.eol && (m_y == ROWS - 1);
    e.ovf = m_ovf;
    exp_q.push_back(e);
    i_valid = 1'b1;
    i_sof   = sof;
    i_sol   = sol;
    i_col   = col;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_sof   = 1'b0;
    i_sol   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rstn && o_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk($sformatf("sum#%0d", n_out), 32'(o_sum), 32'(e.sum));
        chk($sformatf("bit#%0d", n_out), 32'(o_bit), 32'(e.b));
        chk($sformatf("x#%0d", n_out),   32'(o_x),   32'(e.x));
        chk($sformatf("y#%0d", n_out),   32'(o_y),   32'(e.y));
        chk($sformatf("eol#%0d", n_out), 32'(o_eol), 32'(e.eol));
        chk($sformatf("eof#%0d", n_out), 32'(o_eof), 32'(e.eof));
        chk($sformatf("ovf#%0d", n_out), 32'(o_ovf), 32'(e.ovf));
      end
      n_out++;
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(o_valid), 32'd0);
    chk({tag, "_bit"},   32'(o_bit),   32'd0);
    chk({tag, "_sum"},   32'(o_sum),   32'd0);
    chk({tag, "_x"},     32'(o_x),     32'd0);
    chk({tag, "_y"},     32'(o_y),     32'd0);
    chk({tag, "_eol"},   32'(o_eol),   32'd0);
    chk({tag, "_eof"},   32'(o_eof),   32'd0);
    chk({tag, "_ovf"},   32'(o_ovf),   32'd0);
  endtask

  function automatic int ramp(input int i);
    return (5 * (i + 1) > 40) ? 40 : 5 * (i + 1);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int gap_cnt[12];
    int gap_sum[12];
    logic [4:0] gap_col[12];

    rstn = 1'b0; i_valid = 1'b0; i_sof = 1'b0; i_sol = 1'b0;
    i_col = '0; i_thresh = 6'd20; i_mode = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rstn = 1'b1;
    idle(2);

    // Defaults without any sof: threshold 20, bit rises at the fourth column.
    send(0, 0, 5'b11111, 5, 0);
    chk("lat1_valid", 32'(o_valid), 32'd0);
    send(0, 0, 5'b11111, 10, 0);
    chk("lat2_valid", 32'(o_valid), 32'd1);
    for (int i = 2; i < 10; i++) send(0, 0, 5'b11111, ramp(i), ramp(i) >= 20);

    // Ramp fill, sliding exit, then a line start mid-run.
    i_thresh = 6'd20; i_mode = 2'd0;
    send(1, 0, 5'b11111, 5, 0);
    for (int i = 1; i < 10; i++) send(0, 0, 5'b11111, ramp(i), ramp(i) >= 20);
    for (int i = 0; i < 8; i++) send(0, 0, 5'b00000, 35 - 5 * i, (35 - 5 * i) >= 20);
    for (int i = 0; i < 3; i++) send(0, 0, 5'b11111, 5 * (i + 1), 0);
    send(0, 1, 5'b01011, 3, 0);
    send(0, 0, 5'b11111, 8, 0);

    // Erode: one missing bit holds the vote low for eight beats.
    i_mode = 2'd1;
    send(1, 0, 5'b11111, 5, 0);
    for (int i = 1; i < 8; i++) send(0, 0, 5'b11111, 5 * (i + 1), i == 7);
    send(0, 0, 5'b11011, 39, 0);
    for (int i = 0; i < 7; i++) send(0, 0, 5'b11111, 39, 0);
    send(0, 0, 5'b11111, 40, 1);

    // Dilate: a single set bit stays visible for exactly eight beats.
    i_mode = 2'd2;
    send(1, 0, 5'b00100, 1, 1);
    for (int i = 1; i < 10; i++) send(0, 0, 5'b00000, (i < 8) ? 1 : 0, i < 8);

    // Bypass: bit follows i_col[2].
    i_mode = 2'd3;
    send(1, 0, 5'b00100, 1, 1);
    send(0, 0, 5'b11011, 5, 0);
    send(0, 0, 5'b00111, 8, 1);
    send(0, 0, 5'b11000, 10, 0);

    // Threshold boundaries: 0 always passes, 41 never does.
    i_mode = 2'd0; i_thresh = 6'd0;
    send(1, 0, 5'b00000, 0, 1);
    send(0, 0, 5'b00000, 0, 1);
    send(0, 0, 5'b00000, 0, 1);
    i_thresh = 6'd41;
    send(1, 0, 5'b11111, 5, 0);
    for (int i = 1; i < 9; i++) send(0, 0, 5'b11111, ramp(i), 0);

    // Mid-frame config changes are ignored until the next sof.
    i_thresh = 6'd10; i_mode = 2'd0;
    send(1, 0, 5'b11111, 5, 0);
    i_thresh = 6'd40; i_mode = 2'd3;
    send(0, 0, 5'b11111, 10, 1);
    send(0, 0, 5'b00000, 10, 1);
    i_mode = 2'd0;
    send(1, 0, 5'b11111, 5, 0);
    for (int i = 1; i < 8; i++) send(0, 0, 5'b11111, 5 * (i + 1), i == 7);

    // Input gaps must not change the sum sequence.
    gap_col = '{5'b11111, 5'b00001, 5'b00011, 5'b00000, 5'b10101, 5'b11110,
                5'b11111, 5'b01000, 5'b00110, 5'b11111, 5'b10000, 5'b01110};
    gap_sum = '{5, 6, 8, 8, 11, 15, 20, 21, 18, 22, 21, 24};
    gap_cnt = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    i_thresh = 6'd20; i_mode = 2'd0;
    for (int i = 0; i < 12; i++) begin
      send(i == 0, 0, gap_col[i], gap_sum[i], gap_sum[i] >= 20);
      gap_cnt[i] = int'($urandom_range(0, 3));
      if (gap_cnt[i] > 0) idle(gap_cnt[i]);
    end

    // Full frame of tags, then column and row overflow, then clear by sof.
    for (int y = 0; y < ROWS; y++) begin
      for (int x = 0; x < COLS; x++) begin
        send((y == 0) && (x == 0), x == 0, 5'b00000, 0, 0);
      end
    end
    send(0, 0, 5'b00000, 0, 0);
    send(0, 1, 5'b00000, 0, 0);
    send(1, 0, 5'b00000, 0, 0);

    // Reset mid-line clears outputs at once and restores the default threshold.
    i_thresh = 6'd2;
    send(1, 0, 5'b11111, 5, 1);
    send(0, 0, 5'b11111, 10, 1);
    send(0, 0, 5'b11111, 15, 1);
    chk("pre_rst_valid", 32'(o_valid), 32'd1);
    rstn = 1'b0;
    #1;
    chk_all_zero("midrst");
    exp_q.delete();
    m_x = 0; m_y = 0; m_seen = 0; m_ovf = 0;
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) send(0, 0, 5'b11111, 5 * (i + 1), i == 3);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain", 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
